// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// firebird7_in_gate1_tessent_data_mux_tdr
// Multi-channel IJTAG data-override mux with an embedded capture/shift/update
// test data register. Each channel selects functional data, IJTAG data, or a
// frozen copy of the last functional value. The data path is purely
// combinational; only the mode register and the per-channel hold copies are
// sequential.
//
// Access protocol: capture/shift/update act only while ijtag_sel is high and
// resolve with priority capture > shift > update on each rising ijtag_tck.
// With ijtag_sel low, or with no enable asserted, the scan and mode registers
// hold. Capture loads the current modes into the scan register for readback.
// Shift moves the scan register toward bit 0 (ijtag_so), taking ijtag_si in
// at the top. Update copies the scan register into the mode register.

module firebird7_in_gate1_tessent_data_mux_tdr #(
  parameter int NUM_CHANNELS = 4,
  parameter int WIDTH        = 3
) (
  input  logic                          ijtag_tck,
  input  logic                          ijtag_reset,
  input  logic                          ijtag_sel,
  input  logic                          ijtag_ce,
  input  logic                          ijtag_se,
  input  logic                          ijtag_ue,
  input  logic                          ijtag_si,
  output logic                          ijtag_so,
  input  logic [NUM_CHANNELS*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CHANNELS*WIDTH-1:0] ijtag_data_in,
  output logic [NUM_CHANNELS*WIDTH-1:0] data_out
);

  localparam int SR_W = 2 * NUM_CHANNELS;

  // Two mode bits per channel: 00 functional, 01 IJTAG, 10 hold, 11 functional.
  localparam logic [1:0] MODE_IJTAG = 2'b01;
  localparam logic [1:0] MODE_HOLD  = 2'b10;

  logic [SR_W-1:0]  shift_reg;
  logic [SR_W-1:0]  update_reg;
  logic [WIDTH-1:0] hold_reg [NUM_CHANNELS];

  // Scan and mode registers: capture beats shift beats update, all gated by sel.
  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      shift_reg  <= '0;
      update_reg <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        shift_reg <= update_reg;
      end else if (ijtag_se) begin
        shift_reg <= {ijtag_si, shift_reg[SR_W-1:1]};
      end else if (ijtag_ue) begin
        update_reg <= shift_reg;
      end
    end
  end

  // Hold copies track functional data until the channel's current mode is hold.
  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hold_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (update_reg[2*c +: 2] != MODE_HOLD) begin
          hold_reg[c] <= functional_data_in[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Output mux per channel; the reserved code falls through to functional data.
  always_comb begin
    data_out = functional_data_in;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (update_reg[2*c +: 2])
        MODE_IJTAG: data_out[c*WIDTH +: WIDTH] = ijtag_data_in[c*WIDTH +: WIDTH];
        MODE_HOLD:  data_out[c*WIDTH +: WIDTH] = hold_reg[c];
        default:    data_out[c*WIDTH +: WIDTH] = functional_data_in[c*WIDTH +: WIDTH];
      endcase
    end
  end

  assign ijtag_so = shift_reg[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Bench for firebird7_in_gate1_tessent_data_mux_tdr with N=4, W=3.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;

  localparam int N = 4;
  localparam int W = 3;
  localparam int DW = N * W;

  logic          clk;
  logic          rst_n;
  logic          sel, ce, se, ue, si;
  logic          so;
  logic [DW-1:0] func, ijd;
  logic [DW-1:0] data_out;

  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  firebird7_in_gate1_tessent_data_mux_tdr #(
    .NUM_CHANNELS(N),
    .WIDTH(W)
  ) dut (
    .ijtag_tck         (clk),
    .ijtag_reset       (rst_n),
    .ijtag_sel         (sel),
    .ijtag_ce          (ce),
    .ijtag_se          (se),
    .ijtag_ue          (ue),
    .ijtag_si          (si),
    .ijtag_so          (so),
    .functional_data_in(func),
    .ijtag_data_in     (ijd),
    .data_out          (data_out)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [7:0] v);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = v[i];
      cyc();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic do_update();
    sel = 1'b1;
    ue  = 1'b1;
    cyc();
    ue  = 1'b0;
  endtask

  task automatic do_capture();
    sel = 1'b1;
    ce  = 1'b1;
    cyc();
    ce  = 1'b0;
  endtask

  // Reads out the scan register after a capture and compares each bit.
  task automatic test_so_stream(input string name, input logic [7:0] v);
    logic [DW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({{(DW-1){1'b0}}, v[i]});
    end
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({{(DW-1){1'b0}}, so} !== e) begin
        n_fail++;
        $display("FAIL %s bit %0d: so got %b expected %b", name, i, so, e[0]);
      end
      si = 1'b0;
      se = 1'b1;
      cyc();
    end
    se = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] e;
    rst_n = 1'b0;
    func  = 12'hABC;
    ijd   = 12'h123;
    cyc();
    cyc();
    exp_q.push_back(12'hABC);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h expected %h", data_out, e);
    end
    exp_q.push_back('0);
    e = exp_q.pop_front();
    n_checks++;
    if ({{(DW-1){1'b0}}, so} !== e) begin
      n_fail++;
      $display("FAIL reset_so: got %b expected 0", so);
    end
    rst_n = 1'b1;
    do_capture();
    test_so_stream("reset_readback", 8'h00);
  endtask

  task automatic test_program_override();
    logic [DW-1:0] e;
    func = 12'hFFF;
    ijd  = 12'h000;
    shift_in(8'h11);
    ue = 1'b1;
    #1;
    exp_q.push_back(12'hFFF);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL override_before_update: got %h expected %h", data_out, e);
    end
    cyc();
    ue = 1'b0;
    exp_q.push_back(12'hE38);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL override_after_update: got %h expected %h", data_out, e);
    end
    for (int k = 0; k < 3; k++) begin
      func = DW'($urandom_range(0, 4095));
      ijd  = DW'($urandom_range(0, 4095));
      #1;
      exp_q.push_back((func & ~12'h1C7) | (ijd & 12'h1C7));
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e) begin
        n_fail++;
        $display("FAIL override_random_%0d: got %h expected %h", k, data_out, e);
      end
      cyc();
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] e;
    func = 12'h028;
    ijd  = 12'h000;
    shift_in(8'h08);
    do_update();
    for (int k = 0; k < 3; k++) begin
      func = (DW'($urandom_range(0, 4095)) & 12'hFC7) | 12'h010;
      #1;
      exp_q.push_back((func & 12'hFC7) | 12'h028);
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e) begin
        n_fail++;
        $display("FAIL hold_frozen_%0d: got %h expected %h", k, data_out, e);
      end
      cyc();
    end
    func = 12'h010;
    shift_in(8'h08);
    do_update();
    exp_q.push_back(12'h028);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL hold_reenter: got %h expected %h", data_out, e);
    end
    shift_in(8'h00);
    exp_q.push_back(12'h028);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL hold_before_release: got %h expected %h", data_out, e);
    end
    do_update();
    exp_q.push_back(12'h010);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL hold_release: got %h expected %h", data_out, e);
    end
    func = 12'h038;
    #1;
    exp_q.push_back(12'h038);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL hold_release_track: got %h expected %h", data_out, e);
    end
    cyc();
  endtask

  task automatic test_readback_priority();
    logic [DW-1:0] e;
    func = 12'h000;
    ijd  = 12'hFFF;
    shift_in(8'h9C);
    do_update();
    do_capture();
    test_so_stream("readback_9c", 8'h9C);
    // scan register now holds 0x00; capture must win over update
    sel = 1'b1;
    ce  = 1'b1;
    ue  = 1'b1;
    cyc();
    ce  = 1'b0;
    ue  = 1'b0;
    exp_q.push_back(12'h1C0);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL prio_capture_update: got %h expected %h", data_out, e);
    end
    se = 1'b1;
    ue = 1'b1;
    si = 1'b0;
    cyc();
    se = 1'b0;
    ue = 1'b0;
    exp_q.push_back(12'h1C0);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL prio_shift_update: got %h expected %h", data_out, e);
    end
  endtask

  task automatic test_select_reserved();
    logic [DW-1:0] e;
    // scan register is 0x4E here; a shift would put a 1 on so
    sel = 1'b0;
    se  = 1'b1;
    ue  = 1'b1;
    si  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp_q.push_back('0);
      e = exp_q.pop_front();
      n_checks++;
      if ({{(DW-1){1'b0}}, so} !== e) begin
        n_fail++;
        $display("FAIL sel_gate_so_%0d: got %b expected 0", k, so);
      end
    end
    se = 1'b0;
    ue = 1'b0;
    si = 1'b0;
    exp_q.push_back(12'h1C0);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL sel_gate_modes: got %h expected %h", data_out, e);
    end
    do_capture();
    test_so_stream("sel_gate_readback", 8'h9C);
    shift_in(8'hC0);
    do_update();
    for (int k = 0; k < 3; k++) begin
      func = DW'($urandom_range(0, 4095));
      ijd  = ~func;
      #1;
      exp_q.push_back(func);
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e) begin
        n_fail++;
        $display("FAIL reserved_%0d: got %h expected %h", k, data_out, e);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    func = 12'h5A5;
    ijd  = 12'h3C2;
    shift_in(8'h01);
    do_update();
    exp_q.push_back(12'h5A2);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL midreset_ijtag: got %h expected %h", data_out, e);
    end
    sel = 1'b1;
    se  = 1'b1;
    si  = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    se    = 1'b0;
    si    = 1'b0;
    exp_q.push_back(12'h5A5);
    e = exp_q.pop_front();
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL midreset_func: got %h expected %h", data_out, e);
    end
    do_capture();
    test_so_stream("midreset_readback", 8'h00);
  endtask

  // Sequencer and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    sel = 1'b0;
    ce  = 1'b0;
    se  = 1'b0;
    ue  = 1'b0;
    si  = 1'b0;
    func = '0;
    ijd  = '0;
    test_reset();
    test_program_override();
    test_hold();
    test_readback_priority();
    test_select_reserved();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
